// File: rtl/fht_pkg.sv
// Shared constants, bank address type, FSM states and bit-reverse helper
// for the FHT sequencer.
package fht_pkg;

  localparam int N        = 1024;
  localparam int A_BIT    = $clog2(N / 4);
  localparam int S        = A_BIT + 2;
  localparam int PIPE_LAT = 4;
  localparam int S_W      = $clog2(S);
  localparam int LP_W     = $clog2(A_BIT + 1);

  typedef logic [A_BIT-1:0] bank_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } fht_state_t;

  function automatic bank_addr_t bitrev(input bank_addr_t x);
    bank_addr_t r;
    for (int i = 0; i < A_BIT; i++) r[i] = x[A_BIT-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fht_addr_gen.sv
// Combinational (stage, t) -> bank read addresses, sector, subsector half and
// twiddle address; zero latency. FHT_BITREV_EN selects bit-reversed stage-0 reads.
module fht_addr_gen
  import fht_pkg::*;
(
  input  logic [S_W-1:0]   stage,
  input  logic [A_BIT-1:0] t,
  output logic [A_BIT-1:0] rd_lo,
  output logic [A_BIT-1:0] rd_hi,
  output logic [A_BIT-1:0] sector,
  output logic [A_BIT-1:0] coef,
  output logic             second_half
);

  logic [LP_W-1:0]  lp;
  logic [A_BIT-1:0] mask;
  logic [A_BIT-1:0] m;
  logic [A_BIT-1:0] mirror;

  always_comb begin
    lp          = (stage > S_W'(A_BIT)) ? LP_W'(A_BIT) : LP_W'(stage);
    // mask = P-1; shifting all-ones out completely gives P = 2^A_BIT
    mask        = ~({A_BIT{1'b1}} << lp);
    m           = t & mask;
    mirror      = (t & ~mask) | ((A_BIT'(0) - m) & mask);
    rd_lo       = t;
    rd_hi       = mirror;
    sector      = t >> lp;
    coef        = m << (LP_W'(A_BIT) - lp);
    second_half = (m & ~(mask >> 1)) != '0;
    if (stage == '0) begin
`ifdef FHT_BITREV_EN
      rd_lo = bitrev(t);
`else
      rd_lo = t;
`endif
      rd_hi       = rd_lo;
      sector      = '0;
      coef        = '0;
      second_half = 1'b0;
    end
  end

endmodule

// File: rtl/fht_control.sv
// FHT stage sequencer: start pulse runs S stages of N/4 reads plus PIPE_LAT flush;
// writes trail reads by PIPE_LAT cycles, no backpressure. Uses FHT_BITREV_EN via fht_addr_gen.
module fht_control
  import fht_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic             o2ND_PART_SUBSEC,
  output logic [A_BIT-1:0] oSECTOR,
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  output logic [A_BIT-1:0] oADDR_WR_0,
  output logic [A_BIT-1:0] oADDR_WR_1,
  output logic [A_BIT-1:0] oADDR_WR_2,
  output logic [A_BIT-1:0] oADDR_WR_3,
  output logic [A_BIT-1:0] oADDR_COEF,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic             oSOURCE_DATA,
  output logic             oSOURCE_CONT,
  output logic             oRDY
);

  localparam int F_W = $clog2(PIPE_LAT + 1);

  fht_state_t       state, state_nxt;
  logic [S_W-1:0]   stage, stage_nxt;
  bank_addr_t       t, t_nxt;
  logic [F_W-1:0]   flush_cnt, flush_cnt_nxt;
  logic             eof_read;
  bank_addr_t       rd_lo, rd_hi;
  logic [PIPE_LAT-1:0] vld_d;
  bank_addr_t       wr_lo_d [PIPE_LAT];
  bank_addr_t       wr_hi_d [PIPE_LAT];

  assign eof_read = (state == ST_RUN) && (t == bank_addr_t'(N / 4 - 1));

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state     <= ST_IDLE;
      stage     <= '0;
      t         <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stage     <= stage_nxt;
      t         <= t_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    stage_nxt     = stage;
    t_nxt         = t;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_IDLE: begin
        if (iSTART) begin
          state_nxt = ST_RUN;
          stage_nxt = '0;
          t_nxt     = '0;
        end
      end
      ST_RUN: begin
        // t parks on its last value so read addresses hold through the flush
        if (eof_read) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == F_W'(PIPE_LAT - 1)) begin
          if (stage == S_W'(S - 1)) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RUN;
            stage_nxt = stage + 1'b1;
            t_nxt     = '0;
          end
        end else begin
          flush_cnt_nxt = flush_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  fht_addr_gen u_addr_gen (
    .stage       (stage),
    .t           (t),
    .rd_lo       (rd_lo),
    .rd_hi       (rd_hi),
    .sector      (oSECTOR),
    .coef        (oADDR_COEF),
    .second_half (o2ND_PART_SUBSEC)
  );

  // Write side mirrors the butterfly pipeline: read valid and addresses delayed PIPE_LAT
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      vld_d <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_lo_d[i] <= '0;
        wr_hi_d[i] <= '0;
      end
    end else begin
      vld_d[0]   <= (state == ST_RUN);
      wr_lo_d[0] <= rd_lo;
      wr_hi_d[0] <= rd_hi;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_d[i]   <= vld_d[i-1];
        wr_lo_d[i] <= wr_lo_d[i-1];
        wr_hi_d[i] <= wr_hi_d[i-1];
      end
    end
  end

  assign oADDR_RD_0   = rd_lo;
  assign oADDR_RD_1   = rd_lo;
  assign oADDR_RD_2   = rd_hi;
  assign oADDR_RD_3   = rd_hi;
  assign oADDR_WR_0   = wr_lo_d[PIPE_LAT-1];
  assign oADDR_WR_1   = wr_lo_d[PIPE_LAT-1];
  assign oADDR_WR_2   = wr_hi_d[PIPE_LAT-1];
  assign oADDR_WR_3   = wr_hi_d[PIPE_LAT-1];
  assign oWE_A        = vld_d[PIPE_LAT-1] & stage[0];
  assign oWE_B        = vld_d[PIPE_LAT-1] & ~stage[0];
  assign oSOURCE_DATA = stage[0];
  assign oRDY         = (state == ST_IDLE);
  assign oSOURCE_CONT = ~oRDY;
  assign oST_ZERO     = ~oRDY && (stage == '0);
  assign oST_LAST     = ~oRDY && (stage == S_W'(S - 1));

endmodule

// File: tb/tb_fht_control.sv
// Directed bench for fht_control (N=1024, PIPE_LAT=4) with a write-address scoreboard.
module tb_fht_control;

  localparam int NQ      = 256;
  localparam int STG_LEN = 260;
  localparam int TOTAL   = 2600;
`ifdef FHT_BITREV_EN
  localparam int DIR_T1 = 128, DIR_T3 = 192;
`else
  localparam int DIR_T1 = 1, DIR_T3 = 3;
`endif

  logic       iCLK = 1'b0;
  logic       iRESET, iSTART;
  logic       oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
  logic [7:0] oSECTOR, oADDR_COEF;
  logic [7:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [7:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic       oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT, oRDY;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int q_lo[$];
  int q_hi[$];

  always #5 iCLK = ~iCLK;

  fht_control dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST), .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC),
    .oSECTOR(oSECTOR),
    .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1),
    .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
    .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
    .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
    .oADDR_COEF(oADDR_COEF), .oWE_A(oWE_A), .oWE_B(oWE_B),
    .oSOURCE_DATA(oSOURCE_DATA), .oSOURCE_CONT(oSOURCE_CONT), .oRDY(oRDY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int m_brv(input int t);
    int r = 0;
    for (int i = 0; i < 8; i++) if (((t >> i) & 1) != 0) r |= 1 << (7 - i);
    return r;
  endfunction

  function automatic int m_p(input int s);
    return 1 << ((s < 8) ? s : 8);
  endfunction

  function automatic int m_rd_lo(input int s, input int t);
    if (s != 0) return t;
`ifdef FHT_BITREV_EN
    return m_brv(t);
`else
    return t;
`endif
  endfunction

  function automatic int m_rd_hi(input int s, input int t);
    int p;
    if (s == 0) return m_rd_lo(s, t);
    p = m_p(s);
    return (t - t % p) + ((p - t % p) % p);
  endfunction

  // Check one cycle against the model, then advance to the next sampling point
  task automatic step();
    int  s, cc, t, p, lo, hi;
    bit  busy;
    busy = cyc < TOTAL;
    s    = cyc / STG_LEN;
    cc   = cyc % STG_LEN;
    t    = (cc < NQ) ? cc : NQ - 1;
    p    = m_p(s);
    chk("rdy", 32'(oRDY), 32'(!busy));
    chk("src_cont", 32'(oSOURCE_CONT), 32'(busy));
    chk("we_a", 32'(oWE_A), 32'(busy && (s % 2 == 1) && cc >= 4));
    chk("we_b", 32'(oWE_B), 32'(busy && (s % 2 == 0) && cc >= 4));
    if (busy) begin
      chk("src_data", 32'(oSOURCE_DATA), 32'(s % 2));
      chk("st_zero", 32'(oST_ZERO), 32'(s == 0));
      chk("st_last", 32'(oST_LAST), 32'(s == 9));
      chk("rd0", 32'(oADDR_RD_0), 32'(m_rd_lo(s, t)));
      chk("rd1", 32'(oADDR_RD_1), 32'(m_rd_lo(s, t)));
      chk("rd2", 32'(oADDR_RD_2), 32'(m_rd_hi(s, t)));
      chk("rd3", 32'(oADDR_RD_3), 32'(m_rd_hi(s, t)));
      chk("sector", 32'(oSECTOR), 32'((s == 0) ? 0 : t / p));
      chk("second", 32'(o2ND_PART_SUBSEC), 32'((s != 0) && (t % p) >= p / 2));
      chk("coef", 32'(oADDR_COEF), 32'((s == 0) ? 0 : (t % p) * (256 / p)));
      if (cc < NQ) begin
        q_lo.push_back(m_rd_lo(s, t));
        q_hi.push_back(m_rd_hi(s, t));
      end
    end
    case (cyc)
      1:   chk("s0_t1_rd3", 32'(oADDR_RD_3), 32'(DIR_T1));
      3:   chk("s0_t3_rd0", 32'(oADDR_RD_0), 32'(DIR_T3));
      783: begin
        chk("s3_t3_rd1", 32'(oADDR_RD_1), 32'd3);
        chk("s3_t3_rd2", 32'(oADDR_RD_2), 32'd5);
        chk("s3_t3_coef", 32'(oADDR_COEF), 32'd96);
      end
      789: begin
        chk("s3_t9_rd3", 32'(oADDR_RD_3), 32'd15);
        chk("s3_t9_sector", 32'(oSECTOR), 32'd1);
        chk("s3_t9_second", 32'(o2ND_PART_SUBSEC), 32'd0);
      end
      default: ;
    endcase
    if (oWE_A || oWE_B) begin
      chk("sb_nonempty", 32'(q_lo.size() != 0), 32'd1);
      if (q_lo.size() != 0) begin
        lo = q_lo.pop_front();
        hi = q_hi.pop_front();
        chk("wr0", 32'(oADDR_WR_0), 32'(lo));
        chk("wr1", 32'(oADDR_WR_1), 32'(lo));
        chk("wr2", 32'(oADDR_WR_2), 32'(hi));
        chk("wr3", 32'(oADDR_WR_3), 32'(hi));
      end
    end
    cyc++;
    @(negedge iCLK);
  endtask

  initial begin
    iRESET = 1'b1;
    iSTART = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("rst_rdy", 32'(oRDY), 32'd1);
    chk("rst_we", 32'({oWE_A, oWE_B}), 32'd0);
    chk("rst_src", 32'({oSOURCE_DATA, oSOURCE_CONT}), 32'd0);
    chk("rst_flags", 32'({oST_ZERO, oST_LAST, o2ND_PART_SUBSEC}), 32'd0);
    chk("rst_rd", 32'({oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}), 32'd0);
    chk("rst_wr", 32'({oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3}), 32'd0);
    chk("rst_sec_coef", 32'({oSECTOR, oADDR_COEF}), 32'd0);
    iRESET = 1'b0;
    @(negedge iCLK);
    chk("idle_rdy", 32'(oRDY), 32'd1);

    // Full run with a stray start pulse mid-run
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    cyc = 0;
    repeat (1000) step();
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    repeat (TOTAL + 10 - 1001) step();
    chk("sb_drain", 32'(q_lo.size()), 32'd0);

    // Abort with reset during stage 5
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    cyc = 0;
    repeat (5 * STG_LEN + 50) step();
    iRESET = 1'b1;
    #1;
    chk("abort_rdy", 32'(oRDY), 32'd1);
    chk("abort_we", 32'({oWE_A, oWE_B}), 32'd0);
    chk("abort_src", 32'(oSOURCE_DATA), 32'd0);
    q_lo.delete();
    q_hi.delete();
    repeat (2) @(negedge iCLK);
    iRESET = 1'b0;
    repeat (3) begin
      @(negedge iCLK);
      chk("post_abort_we", 32'({oWE_A, oWE_B}), 32'd0);
      chk("post_abort_rdy", 32'(oRDY), 32'd1);
    end

    // Fresh start after the abort covers stage 0 and the move to stage 1
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    cyc = 0;
    repeat (2 * STG_LEN) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
